// File: rtl/lane_op_pipe.sv
// lane_op_pipe: multi-lane, two-operand arithmetic/logic pipeline with valid/ready
// handshakes on both sides and bubble-collapsing stages.
//
// Parameters:
//   W  - lane width in bits (>= 2)
//   N  - number of independent lanes (>= 1)
//   D  - register stages (>= 1), equal to unstalled latency
//   CW - width of done_cnt
//
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset, sync release
//   in_valid / in_ready - input handshake; in_ready is combinational
//   in_op               - opcode shared by all lanes:
//                         0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MIN, 6 MAX, 7 PASS_A
//   in_a, in_b          - operands, lane k at [k*W +: W]
//   out_valid/out_ready - output handshake
//   out_y, out_flag     - result per lane and carry (ADD) / borrow (SUB) flag per lane
//   busy                - any stage holds a beat
//   done_cnt            - number of output transfers, wrapping
//
// Build option: define LANE_OP_PIPE_SAT_EN to saturate ADD to all-ones on carry and
// SUB to zero on borrow; the flags still report carry/borrow.

module lane_op_pipe #(
    parameter int unsigned W  = 10,
    parameter int unsigned N  = 2,
    parameter int unsigned D  = 3,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [N*W-1:0]  in_a,
    input  logic [N*W-1:0]  in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_y,
    output logic [N-1:0]    out_flag,
    output logic            busy,
    output logic [CW-1:0]   done_cnt
);

    localparam int unsigned NW = N * W;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpMin = 3'd5;
    localparam logic [2:0] OpMax = 3'd6;

    logic [D-1:0]          v_q, v_d;
    logic [D-1:0][NW-1:0]  y_q, y_d;
    logic [D-1:0][N-1:0]   f_q, f_d;
    logic [CW-1:0]         done_cnt_q, done_cnt_d;

    logic [D-1:0]          adv;
    logic [D-1:0]          load;
    logic [NW-1:0]         op_y;
    logic [N-1:0]          op_f;

    // Ready ripples from the output back to stage 0; an empty stage always loads.
    always_comb begin : p_chain
        logic rdy;
        rdy  = out_ready;
        adv  = '0;
        load = '0;
        for (int i = int'(D) - 1; i >= 0; i--) begin
            adv[i]  = v_q[i] & rdy;
            load[i] = ~v_q[i] | rdy;
            rdy     = load[i];
        end
    end

    // Per-lane operation on the incoming beat.
    always_comb begin : p_op
        logic [W-1:0] a, b, r;
        logic [W:0]   s, d;
        logic         fl;
        op_y = '0;
        op_f = '0;
        for (int k = 0; k < int'(N); k++) begin
            a  = in_a[k*W +: W];
            b  = in_b[k*W +: W];
            s  = {1'b0, a} + {1'b0, b};
            d  = {1'b0, a} - {1'b0, b};
            r  = a;
            fl = 1'b0;
            case (in_op)
                OpAdd: begin
                    fl = s[W];
`ifdef LANE_OP_PIPE_SAT_EN
                    r  = fl ? {W{1'b1}} : s[W-1:0];
`else
                    r  = s[W-1:0];
`endif
                end
                OpSub: begin
                    // Top bit of the extended difference is set exactly when a < b.
                    fl = d[W];
`ifdef LANE_OP_PIPE_SAT_EN
                    r  = fl ? {W{1'b0}} : d[W-1:0];
`else
                    r  = d[W-1:0];
`endif
                end
                OpAnd:   r = a & b;
                OpOr:    r = a | b;
                OpXor:   r = a ^ b;
                OpMin:   r = (a < b) ? a : b;
                OpMax:   r = (a > b) ? a : b;
                default: r = a;
            endcase
            op_y[k*W +: W] = r;
            op_f[k]        = fl;
        end
    end

    always_comb begin : p_next
        v_d = v_q;
        y_d = y_q;
        f_d = f_q;
        if (load[0]) begin
            v_d[0] = in_valid;
            // Data only loads on accept so idle inputs never reach the stages.
            if (in_valid) begin
                y_d[0] = op_y;
                f_d[0] = op_f;
            end
        end
        for (int i = 1; i < int'(D); i++) begin
            if (load[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    y_d[i] = y_q[i-1];
                    f_d[i] = f_q[i-1];
                end
            end
        end
        done_cnt_d = done_cnt_q + {{(CW-1){1'b0}}, adv[D-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            y_q        <= '0;
            f_q        <= '0;
            done_cnt_q <= '0;
        end else begin
            v_q        <= v_d;
            y_q        <= y_d;
            f_q        <= f_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[D-1];
    assign out_y     = y_q[D-1];
    assign out_flag  = f_q[D-1];
    assign busy      = |v_q;
    assign done_cnt  = done_cnt_q;

endmodule
